rtc_bus_scheduler: RTL

- Owns the shared RTC address/data bus and decides which sequencer drives it.
- Two clients share the bus:
  - the periodic read-scan sequencer, which walks command, clock, date and timer registers and raises a final flag when done;
  - the user write/configuration sequencer, which programs time, date and timer values.
- Generates the periodic refresh trigger, grants the bus to one client at a time, and guards each grant with a watchdog.
- Sits between the top-level control FSM and the two RTC sequencers.

---
 rtl/rtc_bus_scheduler_if.sv | 23 ++
 rtl/rtc_bus_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rtc_bus_scheduler_if.sv
// Bus-ownership handshake between the RTC bus scheduler and its two sequencer clients.
interface rtc_bus_scheduler_if;
    logic       rd_start;
    logic       rd_final;
    logic       wr_req;
    logic       wr_done;
    logic       wr_grant;
    logic [1:0] bus_owner;
    logic       scan_valid;
    logic       refresh_pending;
    logic       err_timeout;
    logic       err_clr;

    modport master (
        output rd_start, wr_grant, bus_owner, scan_valid, refresh_pending, err_timeout,
        input  rd_final, wr_req, wr_done, err_clr
    );

    modport slave (
        input  rd_start, wr_grant, bus_owner, scan_valid, refresh_pending, err_timeout,
        output rd_final, wr_req, wr_done, err_clr
    );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the shared RTC bus between the periodic read-scan and user write sequencers,
// generating the refresh trigger and guarding every grant with a watchdog.
module rtc_bus_scheduler #(
    parameter int REFRESH_CYCLES = 1000000,
    parameter int CNT_W          = 20,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    rtc_bus_scheduler_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GRANT_RD = 2'b01,
        ST_GRANT_WR = 2'b10,
        ST_RELEASE  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_n_s;
    logic [CNT_W-1:0]  ref_cnt_r;
    logic [TO_W-1:0]   wd_cnt_r;
    logic              last_wr_r;
    logic              rd_start_r;
    logic              wr_grant_r;
    logic [1:0]        bus_owner_r;
    logic              scan_valid_r;
    logic              refresh_pending_r;
    logic              err_timeout_r;

    logic              wrap_s;
    logic              wd_hit_s;
    logic              enter_rd_s;
    logic              enter_wr_s;
    logic              scan_done_s;
    logic              timeout_s;
    logic [1:0]        owner_n_s;

    assign wrap_s   = (ref_cnt_r == CNT_W'(REFRESH_CYCLES - 1));
    assign wd_hit_s = (wd_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state arbitration and completion/timeout decode.
    always_comb begin
        state_n_s   = state_r;
        enter_rd_s  = 1'b0;
        enter_wr_s  = 1'b0;
        scan_done_s = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Read wins only if the writer is idle or just had its turn: alternation.
                if (refresh_pending_r && (!bus.wr_req || last_wr_r)) begin
                    state_n_s  = ST_GRANT_RD;
                    enter_rd_s = 1'b1;
                end else if (bus.wr_req) begin
                    state_n_s  = ST_GRANT_WR;
                    enter_wr_s = 1'b1;
                end else begin
                    state_n_s  = ST_IDLE;
                end
            end
            ST_GRANT_RD: begin
                if (bus.rd_final) begin
                    state_n_s   = ST_RELEASE;
                    scan_done_s = 1'b1;
                end else if (wd_hit_s) begin
                    state_n_s = ST_RELEASE;
                    timeout_s = 1'b1;
                end else begin
                    state_n_s = ST_GRANT_RD;
                end
            end
            ST_GRANT_WR: begin
                if (bus.wr_done || !bus.wr_req) begin
                    state_n_s = ST_RELEASE;
                end else if (wd_hit_s) begin
                    state_n_s = ST_RELEASE;
                    timeout_s = 1'b1;
                end else begin
                    state_n_s = ST_GRANT_WR;
                end
            end
            ST_RELEASE: state_n_s = ST_IDLE;
            default:    state_n_s = ST_IDLE;
        endcase
    end

    // Owner encoding follows the next state so the registered output lines up with the grant.
    always_comb begin
        case (state_n_s)
            ST_GRANT_RD: owner_n_s = 2'b01;
            ST_GRANT_WR: owner_n_s = 2'b10;
            default:     owner_n_s = 2'b00;
        endcase
    end

    // State, counters and arbitration history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            ref_cnt_r <= {CNT_W{1'b0}};
            wd_cnt_r  <= {TO_W{1'b0}};
            last_wr_r <= 1'b1;
        end else begin
            state_r   <= state_n_s;
            ref_cnt_r <= wrap_s ? {CNT_W{1'b0}} : ref_cnt_r + CNT_W'(1);
            if (enter_rd_s || enter_wr_s) begin
                wd_cnt_r <= {TO_W{1'b0}};
            end else if (state_r == ST_GRANT_RD || state_r == ST_GRANT_WR) begin
                wd_cnt_r <= wd_cnt_r + TO_W'(1);
            end
            if (enter_rd_s) begin
                last_wr_r <= 1'b0;
            end else if (enter_wr_s) begin
                last_wr_r <= 1'b1;
            end
        end
    end

    // Registered outputs; a refresh wrap beats the clear from a simultaneous read grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_start_r        <= 1'b0;
            wr_grant_r        <= 1'b0;
            bus_owner_r       <= 2'b00;
            scan_valid_r      <= 1'b0;
            refresh_pending_r <= 1'b0;
            err_timeout_r     <= 1'b0;
        end else begin
            rd_start_r   <= (state_n_s == ST_GRANT_RD);
            wr_grant_r   <= (state_n_s == ST_GRANT_WR);
            bus_owner_r  <= owner_n_s;
            scan_valid_r <= scan_done_s;
            if (wrap_s) begin
                refresh_pending_r <= 1'b1;
            end else if (enter_rd_s) begin
                refresh_pending_r <= 1'b0;
            end
            if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_timeout_r <= 1'b0;
            end
        end
    end

    assign bus.rd_start        = rd_start_r;
    assign bus.wr_grant        = wr_grant_r;
    assign bus.bus_owner       = bus_owner_r;
    assign bus.scan_valid      = scan_valid_r;
    assign bus.refresh_pending = refresh_pending_r;
    assign bus.err_timeout     = err_timeout_r;

endmodule
